// File: rtl/cus19_pkg.sv
// cus19_pkg: instruction field positions, type codes, ALU and control op codes
package cus19_pkg;
   localparam logic [2:0] TY_ALU = 3'b000, TY_ADDI = 3'b001, TY_MEM = 3'b010;
   localparam logic [2:0] TY_CTRL = 3'b011, TY_CRYPTO = 3'b100, TY_HALT = 3'b111;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4, OP_NOT = 4'd5, OP_MUL = 4'd6;
   localparam logic [3:0] C_JMP = 4'd0, C_BZ = 4'd1, C_CALL = 4'd2, C_RET = 4'd3;
   localparam int OP_HI = 18, OP_LO = 12, A_HI = 11, A_LO = 8, B_HI = 7, B_LO = 4, F_BIT = 3, TY_HI = 2;
endpackage

// File: rtl/cus19_crypto_unit.sv
// cus19_crypto_unit: byte cipher, enc -> rotl3(d ^ key), dec -> rotr3(d) ^ key
module cus19_crypto_unit (
   input  logic [7:0] d,
   input  logic [7:0] key,
   input  logic       enc,
   output logic [7:0] out
);
   logic [7:0] x;
   assign x   = d ^ key;
   assign out = enc ? {x[4:0], x[7:5]} : ({d[2:0], d[7:3]} ^ key);
endmodule

// File: rtl/cus19_mem.sv
// cus19_mem: instruction memory, register file and data memory (async read, sync write, no reset)
module cus19_imem #(parameter int AW = 11, parameter int DW = 19) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wd;
   assign rd = mem[addr];
endmodule

module cus19_regfile #(parameter int AW = 4, parameter int DW = 8) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2
);
   logic [DW-1:0] reg_file [2**AW];
   always_ff @(posedge clk)
      if (we) reg_file[wa] <= wd;
   assign rd1 = reg_file[ra1];
   assign rd2 = reg_file[ra2];
endmodule

module cus19_dmem #(parameter int AW = 8, parameter int DW = 8) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd
);
   logic [DW-1:0] data_mem [2**AW];
   always_ff @(posedge clk)
      if (we) data_mem[addr] <= wd;
   assign rd = data_mem[addr];
endmodule

// File: rtl/cus19_cpu_top.sv
// cus19_cpu_top: single-cycle Custom19 CPU; define CUS19_MUL_EN to enable the 8x8 ALU multiply
module cus19_cpu_top
   import cus19_pkg::*;
#(
   parameter int PC_Width       = 11,
   parameter int Stack_Depth    = 8,
   parameter int Instr_Width    = 19,
   parameter int Data_Width     = 8,
   parameter int Reg_Addr_Width = 4
)(
   input  logic                    cus19_clk_in,
   input  logic                    cus19_rst_in,
   output logic [2*Data_Width-1:0] alu_result_out,
   output logic [2*Data_Width-1:0] ld_result_out
);
   localparam int SIW = $clog2(Stack_Depth);
   localparam int SPW = SIW + 1;
   localparam logic [SPW-1:0] SD = SPW'(Stack_Depth);
   localparam logic [Data_Width-1:0] ZD = '0;
   logic [Instr_Width-1:0] ir;
   logic [6:0] op7;
   logic [Reg_Addr_Width-1:0] a, b;
   logic f;
   logic [2:0] ty;
   logic [3:0] ctop;
   logic [PC_Width-1:0] pc, pc_inc, pc_nxt, tgt;
   logic [PC_Width-1:0] stack [Stack_Depth];
   logic [SPW-1:0] sp;
   logic [SIW-1:0] push_i, top_i;
   logic z, alu_ok, is_alu, is_addi, is_ld, is_st, is_cry, is_call, is_ret, push_ok, pop_ok, reg_we, mem_we;
   logic [Data_Width-1:0] ra, rb, dm_rd, crypt, addi_sum, wd_reg, wd_mem;
   logic [2*Data_Width-1:0] res;

   assign op7  = ir[OP_HI:OP_LO];
   assign a    = ir[A_HI:A_LO];
   assign b    = ir[B_HI:B_LO];
   assign f    = ir[F_BIT];
   assign ty   = ir[TY_HI:0];
   assign ctop = op7[6:3];
   assign tgt  = PC_Width'({op7[2:0], a, b});
   assign pc_inc = pc + PC_Width'(1);

   always_comb begin
      res = '0;
      alu_ok = 1'b1;
      case (op7[3:0])
         OP_ADD: res = {ZD, ra} + {ZD, rb};
         OP_SUB: res = {ZD, ra - rb};
         OP_AND: res = {ZD, ra & rb};
         OP_OR:  res = {ZD, ra | rb};
         OP_XOR: res = {ZD, ra ^ rb};
         OP_NOT: res = {ZD, ~ra};
`ifdef CUS19_MUL_EN
         OP_MUL: res = {ZD, ra} * {ZD, rb};
`endif
         default: alu_ok = 1'b0;
      endcase
   end

   assign is_alu   = ty == TY_ALU && alu_ok;
   assign is_addi  = ty == TY_ADDI;
   assign is_ld    = ty == TY_MEM && f;
   assign is_st    = ty == TY_MEM && !f;
   assign is_cry   = ty == TY_CRYPTO;
   assign is_call  = ty == TY_CTRL && ctop == C_CALL;
   assign is_ret   = ty == TY_CTRL && ctop == C_RET;
   assign push_ok  = sp < SD;
   assign pop_ok   = sp != '0;
   assign push_i   = SIW'(sp);
   assign top_i    = SIW'(sp - SPW'(1));
   assign addi_sum = rb + Data_Width'(op7);
   assign wd_reg   = is_ld ? dm_rd : is_addi ? addi_sum : res[Data_Width-1:0];
   assign wd_mem   = is_cry ? crypt : ra;
   // Memory and register writes are suppressed while reset is held so preloads survive.
   assign reg_we   = cus19_rst_in && (is_alu || is_addi || is_ld);
   assign mem_we   = cus19_rst_in && (is_st || is_cry);

   always_comb
      pc_nxt = ty == TY_HALT ? pc :
               ty != TY_CTRL ? pc_inc :
               (ctop == C_JMP || ctop == C_CALL) ? tgt :
               ctop == C_BZ ? (z ? tgt : pc_inc) :
               (ctop == C_RET && pop_ok) ? stack[top_i] : pc_inc;

   always_ff @(posedge cus19_clk_in) begin
      if (!cus19_rst_in) begin
         pc <= '0;
         sp <= '0;
         z <= 1'b0;
         alu_result_out <= '0;
         ld_result_out <= '0;
      end else begin
         pc <= pc_nxt;
         if (is_call && push_ok) begin
            stack[push_i] <= pc_inc;
            sp <= sp + SPW'(1);
         end else if (is_ret && pop_ok)
            sp <= sp - SPW'(1);
         if (is_alu || is_addi) z <= wd_reg == '0;
         if (is_alu || is_addi || is_cry)
            alu_result_out <= is_cry ? {ZD, crypt} : is_addi ? {ZD, addi_sum} : res;
         if (is_ld) ld_result_out <= {ZD, dm_rd};
      end
   end

   cus19_imem #(.AW(PC_Width), .DW(Instr_Width)) M2 (
      .clk(cus19_clk_in), .we(1'b0), .addr(pc), .wd({Instr_Width{1'b0}}), .rd(ir)
   );
   cus19_regfile #(.AW(Reg_Addr_Width), .DW(Data_Width)) M5 (
      .clk(cus19_clk_in), .we(reg_we), .wa(a), .wd(wd_reg), .ra1(a), .ra2(b), .rd1(ra), .rd2(rb)
   );
   cus19_dmem #(.AW(Data_Width), .DW(Data_Width)) M13 (
      .clk(cus19_clk_in), .we(mem_we), .addr(rb), .wd(wd_mem), .rd(dm_rd)
   );
   cus19_crypto_unit u_crypto (.d(dm_rd), .key(ra), .enc(f), .out(crypt));
endmodule

// File: tb/tb_cus19_cpu_top.sv
// tb_cus19_cpu_top: scoreboard bench, architectural model predicts pc/outputs per executed instruction
module tb_cus19_cpu_top;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] alu, ld;
   typedef struct { logic [10:0] pc; logic [15:0] alu; logic [15:0] ld; } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   logic [18:0] im [2048];
   logic [7:0] R [16];
   logic [7:0] D [256];
   int mpc, stk[$];
   bit mz;
   logic [15:0] malu, mld;

   always #5 clk = ~clk;

   cus19_cpu_top dut (.cus19_clk_in(clk), .cus19_rst_in(rst_n), .alu_result_out(alu), .ld_result_out(ld));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] enc(input int op, input int a, input int b, input int f, input int t);
      return {7'(op), 4'(a), 4'(b), 1'(f), 3'(t)};
   endfunction

   function automatic logic [18:0] rnd_ins();
      int t, op;
      t = $urandom_range(0, 6);
      if (t == 6) t = ($urandom_range(0, 63) == 0) ? 7 : int'($urandom_range(5, 6));
      op = $urandom_range(0, 127);
      if (t == 0) op = int'($urandom_range(0, 7)) * 16 + int'($urandom_range(0, 7));
      if (t == 3) op = int'($urandom_range(0, 4)) * 8;
      return enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), t);
   endfunction

   // Architectural step: plain integer arithmetic straight from the instruction set rules
   task automatic model_step(input bit run);
      int op, a, b, f, t, x, y, r, d, c, npc;
      bit ok;
      if (!run) begin
         mpc = 0; stk.delete(); mz = 0; malu = 0; mld = 0;
      end else begin
         op = int'(im[mpc][18:12]); a = int'(im[mpc][11:8]); b = int'(im[mpc][7:4]);
         f = int'(im[mpc][3]); t = int'(im[mpc][2:0]);
         x = int'(R[a]); y = int'(R[b]); npc = (mpc + 1) % 2048; r = 0; ok = 1;
         case (t)
            0: begin
               case (op % 16)
                  0: r = x + y;
                  1: r = (x - y + 256) % 256;
                  2: r = x & y;
                  3: r = x | y;
                  4: r = x ^ y;
                  5: r = 255 - x;
                  6: begin
`ifdef CUS19_MUL_EN
                     r = x * y;
`else
                     ok = 0;
`endif
                  end
                  default: ok = 0;
               endcase
               if (ok) begin R[a] = 8'(r); malu = 16'(r); mz = (r % 256) == 0; end
            end
            1: begin r = (y + op) % 256; R[a] = 8'(r); malu = 16'(r); mz = r == 0; end
            2: if (f == 1) begin mld = {8'h00, D[y]}; R[a] = D[y]; end else D[y] = 8'(x);
            3: begin
               r = (op % 8) * 256 + a * 16 + b;
               case (op / 8)
                  0: npc = r;
                  1: if (mz) npc = r;
                  2: begin if (stk.size() < 8) stk.push_back(npc); npc = r; end
                  3: if (stk.size() > 0) npc = stk.pop_back();
                  default: ;
               endcase
            end
            4: begin
               d = int'(D[y]);
               if (f == 1) begin r = d ^ x; c = ((r * 8) + (r / 32)) % 256; end
               else c = (((d / 8) + (d * 32)) % 256) ^ x;
               D[y] = 8'(c); malu = 16'(c);
            end
            7: npc = mpc;
            default: ;
         endcase
         mpc = npc;
      end
   endtask

   task automatic run(input int n, input int rst_at);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n = (i != rst_at);
         model_step(rst_n);
         e.pc = 11'(mpc); e.alu = malu; e.ld = mld;
         q.push_back(e);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_and_load();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_pc", 32'(dut.pc), 0);
      chk("rst_sp", 32'(dut.sp), 0);
      chk("rst_alu", 32'(alu), 0);
      chk("rst_ld", 32'(ld), 0);
      model_step(0);
      for (int i = 0; i < 2048; i++) dut.M2.mem[i] <= im[i];
      for (int i = 0; i < 16; i++) dut.M5.reg_file[i] <= R[i];
      for (int i = 0; i < 256; i++) dut.M13.data_mem[i] <= D[i];
   endtask

   task automatic randomize_state(input bit rnd_prog);
      for (int i = 0; i < 16; i++) R[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) D[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) im[i] = rnd_prog ? rnd_ins() : enc(0, 0, 0, 0, 7);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", 32'(dut.pc), 32'(e.pc));
            chk("alu_result", 32'(alu), 32'(e.alu));
            chk("ld_result", 32'(ld), 32'(e.ld));
         end
      end
   end

   initial begin
      // Directed: crypto examples, ALU carry, store/load, crypto round trip
      randomize_state(0);
      R[1] = 8'hFF; R[2] = 8'h02; R[3] = 8'h03; R[4] = 8'h04; R[5] = 8'h05; R[6] = 8'h5A; R[7] = 8'h80;
      D[3] = 8'h0A; D[5] = 8'h05;
      im[0] = enc(0, 2, 3, 1, 4);
      im[1] = enc(0, 4, 5, 0, 4);
      im[2] = enc(0, 1, 2, 0, 0);
      im[3] = enc(0, 6, 7, 0, 2);
      im[4] = enc(0, 8, 7, 1, 2);
      im[5] = enc(0, 2, 3, 0, 4);
      reset_and_load();
      run(1, -1); settle();
      chk("enc_alu", 32'(alu), 32'h0040);
      chk("enc_mem", 32'(dut.M13.data_mem[3]), 32'h40);
      run(1, -1); settle();
      chk("dec_alu", 32'(alu), 32'h00A4);
      chk("dec_mem", 32'(dut.M13.data_mem[5]), 32'hA4);
      run(1, -1); settle();
      chk("add_alu", 32'(alu), 32'h0101);
      chk("add_reg", 32'(dut.M5.reg_file[1]), 32'h01);
      run(5, -1); settle();
      chk("ld_result", 32'(ld), 32'h005A);
      chk("ld_reg", 32'(dut.M5.reg_file[8]), 32'h5A);
      chk("roundtrip", 32'(dut.M13.data_mem[3]), 32'h0A);
      chk("halt_pc", 32'(dut.pc), 6);

      // Nested calls: eight pushes, the ninth call jumps without pushing
      randomize_state(0);
      for (int k = 0; k < 9; k++) im[k] = enc(16, 0, k + 1, 0, 3);
      im[9] = enc(24, 0, 0, 0, 3);
      reset_and_load();
      run(9, -1); settle();
      chk("call_sp_full", 32'(dut.sp), 8);
      chk("call9_pc", 32'(dut.pc), 9);
      run(1, -1); settle();
      chk("ret_pc", 32'(dut.pc), 8);
      chk("ret_sp", 32'(dut.sp), 7);
      run(20, -1);

      // Random programs with a mid-program reset
      for (int s = 0; s < 2; s++) begin
         randomize_state(1);
         reset_and_load();
         run(400, 200);
         settle();
         for (int i = 0; i < 16; i++) chk("final_reg", 32'(dut.M5.reg_file[i]), 32'(R[i]));
         for (int i = 0; i < 256; i++) chk("final_dmem", 32'(dut.M13.data_mem[i]), 32'(D[i]));
      end
      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
